// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - RV32 instruction packer: scatters a decoded immediate into its format and emits addressed words
module imm_encoder #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int               ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          fmt,
    input  logic [6:0]          opcode,
    input  logic [4:0]          rd,
    input  logic [2:0]          funct3,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [6:0]          funct7,
    input  logic [WIDTH-1:0]    imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_instr,
    output logic [WIDTH-1:0]    out_addr,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] next_addr;
    logic             accept;
    logic [WIDTH-1:0] pack_instr;
    logic             pack_err;
    logic             fits12;
    logic             fits13;
    logic             fits21;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // An immediate fits when every bit above the field's sign bit copies it.
    assign fits12 = (&imm[WIDTH-1:11]) || !(|imm[WIDTH-1:11]);
    assign fits13 = (&imm[WIDTH-1:12]) || !(|imm[WIDTH-1:12]);
    assign fits21 = (&imm[WIDTH-1:20]) || !(|imm[WIDTH-1:20]);

    always_comb begin
        pack_instr = '0;
        pack_err   = 1'b0;
        case (fmt)
            3'b000: begin
                pack_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            3'b001: begin
                pack_instr = {imm[11:0], rs1, funct3, rd, opcode};
                pack_err   = !fits12;
            end
            3'b010: begin
                pack_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                pack_err   = !fits12;
            end
            3'b011: begin
                pack_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                pack_err   = !fits13 || imm[0];
            end
            3'b100: begin
                pack_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                pack_err   = !fits21 || imm[0];
            end
            default: begin
                pack_instr = '0;
                pack_err   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            out_err   <= 1'b0;
            err_count <= '0;
            next_addr <= BASE_ADDR;
        end else begin
            if (accept) begin
                out_instr <= pack_instr;
                out_addr  <= next_addr;
                out_err   <= pack_err;
                next_addr <= next_addr + WIDTH'(4);
                if (pack_err && (err_count != {ERRCNT_W{1'b1}}))
                    err_count <= err_count + ERRCNT_W'(1);
            end
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (out_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed and randomized checks of imm_encoder against a field-level reference model
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_err_a;
    logic [31:0] out_instr_a, out_addr_a;
    logic [7:0]  err_count_a;
    logic        in_ready_b, out_valid_b, out_err_b;
    logic [31:0] out_instr_b, out_addr_b;
    logic [1:0]  err_count_b;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] addr_a, addr_b;
    int          cnt_a, cnt_b;

    always #5 clk = ~clk;

    imm_encoder dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_instr(out_instr_a), .out_addr(out_addr_a), .out_err(out_err_a),
        .err_count(err_count_a)
    );

    imm_encoder #(.WIDTH(32), .BASE_ADDR(32'hFFFF_FFF8), .ERRCNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_instr(out_instr_b), .out_addr(out_addr_b), .out_err(out_err_b),
        .err_count(err_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: range by signed arithmetic, placement straight from the format tables.
    function automatic void ref_pack(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                     input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [6:0] f7, input logic [31:0] im,
                                     output logic [31:0] ins, output logic e);
        int s;
        s = im;
        case (f)
            3'd0: begin ins = {f7, s2, s1, f3, d, op}; e = 1'b0; end
            3'd1: begin ins = {im[11:0], s1, f3, d, op}; e = !(s >= -2048 && s <= 2047); end
            3'd2: begin ins = {im[11:5], s2, s1, f3, im[4:0], op}; e = !(s >= -2048 && s <= 2047); end
            3'd3: begin
                ins = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
                e = !(s >= -4096 && s <= 4095) || (s % 2 != 0);
            end
            3'd4: begin
                ins = {im[20], im[10:1], im[11], im[19:12], d, op};
                e = !(s >= -1048576 && s <= 1048575) || (s % 2 != 0);
            end
            default: begin ins = 32'd0; e = 1'b1; end
        endcase
    endfunction

    // The core's immediate generator, used to confirm the round trip.
    function automatic logic [31:0] extract(input logic [31:0] i, input logic [2:0] f);
        case (f)
            3'd1:    return {{20{i[31]}}, i[31:20]};
            3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic beat(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] ei;
        logic        ee;
        fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
        in_valid = 1'b1;
        ref_pack(f, op, d, f3, s1, s2, f7, im, ei, ee);
        #1;
        chk("in_ready_a", 32'(in_ready_a), 32'd1);
        chk("in_ready_b", 32'(in_ready_b), 32'd1);
        @(posedge clk);
        #1;
        if (ee) begin
            cnt_a = (cnt_a < 255) ? cnt_a + 1 : 255;
            cnt_b = (cnt_b < 3) ? cnt_b + 1 : 3;
        end
        chk("out_valid", 32'(out_valid_a), 32'd1);
        chk("out_instr", out_instr_a, ei);
        chk("out_err", 32'(out_err_a), 32'(ee));
        chk("out_addr_a", out_addr_a, addr_a);
        chk("out_addr_b", out_addr_b, addr_b);
        chk("err_count_a", 32'(err_count_a), 32'(cnt_a));
        chk("err_count_b", 32'(err_count_b), 32'(cnt_b));
        if (!ee && f >= 3'd1 && f <= 3'd4)
            chk("roundtrip", extract(out_instr_a, f), im);
        addr_a = addr_a + 32'd4;
        addr_b = addr_b + 32'd4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] h_instr, h_addr, rimm;
        logic [2:0]  rf;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0; imm = '0;
        addr_a = 32'h0; addr_b = 32'hFFFF_FFF8; cnt_a = 0; cnt_b = 0;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_instr", out_instr_a, 32'd0);
        chk("rst_out_addr_a", out_addr_a, 32'd0);
        chk("rst_out_addr_b", out_addr_b, 32'hFFFF_FFF8);
        chk("rst_out_err", 32'(out_err_a), 32'd0);
        chk("rst_err_count", 32'(err_count_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        beat(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        chk("i_const", out_instr_a, 32'h0050_0093);
        chk("i_addr_base", out_addr_a, 32'h0);
        beat(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        chk("s_const", out_instr_a, 32'h0020_A423);
        beat(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, -32'sd4);
        chk("b_const", out_instr_a, 32'hFE00_0EE3);
        chk("wrap_addr_b", out_addr_b, 32'h0);
        beat(3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
        chk("j_const", out_instr_a, 32'h0080_00EF);
        chk("j_addr", out_addr_a, 32'hC);
        beat(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEAD_BEEF);
        chk("r_const", out_instr_a, 32'h0020_81B3);

        h_instr = out_instr_a; h_addr = out_addr_a;
        out_ready = 1'b0;
        fmt = 3'd1; imm = 32'd7;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 32'(in_ready_a), 32'd0);
            chk("stall_valid", 32'(out_valid_a), 32'd1);
            chk("stall_instr", out_instr_a, h_instr);
            chk("stall_addr", out_addr_a, h_addr);
        end
        out_ready = 1'b1;
        beat(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);

        beat(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        chk("err_i2048", 32'(out_err_a), 32'd1);
        beat(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
        chk("err_b3", 32'(out_err_a), 32'd1);
        beat(3'd5, 7'h13, 5'd1, 3'd1, 5'd1, 5'd1, 7'd1, 32'd1);
        chk("resv_instr", out_instr_a, 32'd0);
        chk("err_count_3", 32'(err_count_a), 32'd3);
        beat(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, -32'sd2048);
        chk("err_count_hold", 32'(err_count_a), 32'd3);
        for (int k = 0; k < 5; k++)
            beat(3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        chk("sat_b", 32'(err_count_b), 32'd3);
        chk("count_a_8", 32'(err_count_a), 32'd8);

        out_ready = 1'b0;
        fmt = 3'd1; imm = 32'd1; in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(out_valid_a), 32'd0);
        chk("midrst_count", 32'(err_count_a), 32'd0);
        chk("midrst_count_b", 32'(err_count_b), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        addr_a = 32'h0; addr_b = 32'hFFFF_FFF8; cnt_a = 0; cnt_b = 0;
        beat(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        chk("midrst_addr", out_addr_a, 32'h0);

        for (int n = 0; n < 300; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rimm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: rimm = $urandom;
                2: rimm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
                default: begin
                    case ($urandom_range(0, 5))
                        0: rimm = 32'd2047;
                        1: rimm = 32'd4094;
                        2: rimm = -32'sd4096;
                        3: rimm = 32'd1048574;
                        4: rimm = -32'sd1048576;
                        default: rimm = 32'd1048576;
                    endcase
                end
            endcase
            if ($urandom_range(0, 1) == 1) rimm[0] = 1'b0;
            beat(rf, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                 7'($urandom), rimm);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_valid", 32'(out_valid_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

RV32 instruction packer: the inverse of the core's immediate generator. Accepts decoded fields (format, opcode, registers, functs, immediate) over a valid/ready stream, range-checks the immediate, scatters it into the format's bit positions and emits a 32-bit instruction word plus a sequential word address. It sits in the test/boot path in front of instruction memory (program loader, self-check generator). For every error-free output, re-extracting with the core's immediate generator returns the original immediate.

## Interface
- WIDTH, 32, instruction/immediate width; only 32 is supported.
- BASE_ADDR, 32'h0000_0000, address of the first emitted instruction.
- ERRCNT_W, 8, width of the saturating error counter.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- fmt  in  3  000 R, 001 I, 010 S, 011 B, 100 J; 101–111 reserved.
- opcode  in  7  placed at instr[6:0].
- rd  in  5  instr[11:7] (R/I/J).
- funct3  in  3  instr[14:12] (R/I/S/B).
- rs1  in  5  instr[19:15] (R/I/S/B).
- rs2  in  5  instr[24:20] (R/S/B).
- funct7  in  7  instr[31:25] (R only).
- imm  in  WIDTH  signed immediate, byte offset for B/J.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_instr  out  WIDTH  packed instruction.
- out_addr  out  WIDTH  word address of out_instr.
- out_err  out  1  immediate out of range, misaligned, or reserved fmt.
- err_count  out  ERRCNT_W  saturating count of accepted erroneous beats.

## Operation
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm is ignored.
- Range checks:
  - I/S: imm[31:11] must be all equal (−2048..2047).
  - B: imm[31:12] must be all equal and imm[0] must be 0.
  - J: imm[31:20] must be all equal and imm[0] must be 0.
  - R: never errors.
- On a range or alignment error: out_err=1 and the low bits are packed anyway (truncated).
- Reserved fmt: out_instr=0 and out_err=1.
- Output register FSM:
  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on output handshake with no new accept.
  - FULL stays FULL on a simultaneous output handshake and accept.
- Address:
  - next_addr starts at BASE_ADDR.
  - On accept: out_addr<=next_addr, then next_addr<=next_addr+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- err_count increments on each accepted beat whose out_err is 1, and saturates at 2^ERRCNT_W−1.

## Timing
- in_ready = !out_valid || out_ready (combinational; no combinational path from in_valid to out_*).
- Accept = in_valid && in_ready. Output handshake = out_valid && out_ready.
- Latency: out_instr, out_addr and out_err are registered and valid the cycle after accept.
- Throughput: 1 beat/cycle while out_ready stays high.
- While out_valid=1 and out_ready=0: out_instr, out_addr and out_err hold stable, and in_ready=0.
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0, next_addr=BASE_ADDR.
- Reset mid-stream drops any pending output beat; the first beat after reset gets BASE_ADDR.
- err_count updates in the same edge as the accept of the erroneous beat.

## Test plan
- I-type: opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093, out_addr=BASE_ADDR, out_err=0, one cycle after accept.
- Back-to-back with out_ready=1:
  - S-type: opcode=0x23, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423.
  - B-type: opcode=0x63, rs1=rs2=0, funct3=0, imm=−4 -> 0xFE000EE3.
  - J-type: opcode=0x6F, rd=1, imm=8 -> 0x008000EF.
  - Addresses step by 4; no bubbles.
- R-type: opcode=0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3. Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0. Release: the next beat is accepted the same cycle.
- Errors, err_count 0→3:
  - I imm=2048 -> out_err=1.
  - B imm=3 -> out_err=1.
  - fmt=101 -> out_instr=0 and out_err=1.
  - A following valid I beat does not increment err_count.
- Saturation and wrap:
  - ERRCNT_W=2: 5 erroneous beats -> err_count stays at 3.
  - BASE_ADDR=0xFFFF_FFF8: three beats -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-stream: assert rst_n=0 while FULL -> next edge gives out_valid=0 and err_count=0. The next accepted beat gets out_addr=BASE_ADDR. Random round-trip: for each error-free beat, re-extracting with the core's immediate generator returns imm.
